uart_rx_cfg: RTL
================

# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 `uart_rx`. It generates its own oversampling tick from `clk`, so no external `rx_clk` is needed, and it synchronises the `rx` pin. Data width, parity and stop-bit count are compile-time configurable. Each bit is decided by a 3-sample majority vote. Frames are delivered through a ready/valid holding register with parity, framing, break and overrun status. It sits between the board `rx` pin and the UART command/FIFO logic.

## Interface
- `CLK_DIV`, 23: `clk` cycles per oversample tick (≈41.7 MHz / (115200·16)); legal range ≥2.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥8.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk` in 1: single system clock, all logic on rising edge.
- `rst` in 1: **one clock; reset is synchronous and active-low.**
- `enabled` in 1: receiver enable; low aborts and holds FSM in IDLE.
- `rx` in 1: asynchronous serial input, idle high.
- `data` out DATA_BITS: received word.
- `valid` out 1: `data` and the status flags are valid.
- `ready` in 1: consumer accepts when `valid & ready`.
- `parity_err` out 1: parity mismatch for the held word (0 when PARITY=0).
- `frame_err` out 1: any stop bit voted 0 for the held word.
- `brk` out 1: held word is a break (all data, parity and stop bits voted 0).
- `overrun` out 1: sticky; a frame was dropped because `valid` was pending.
- `busy` out 1: FSM not in IDLE.

## Operation
- Synchroniser: two flops on `rx`, both reset to 1; the FSM uses only `rx_s`.
- Tick counter: free-running 0..CLK_DIV-1. `tick` is asserted for one `clk` when the count equals CLK_DIV-1, then the counter wraps to 0.
- Sample counter `sc`: 0..OVERSAMPLE-1, advances on `tick` while not IDLE. Votes are taken at `sc` = M-1, M and M+1, where M = OVERSAMPLE/2. A bit is majority-of-3.
- FSM states and transitions:
  - IDLE → START on a `tick` with `rx_s`=0. That tick counts as `sc`=0.
  - START → bit end at `sc`=OVERSAMPLE-1 and wrap. Voted 1 means a false start: go to IDLE with no flags. Voted 0 goes to DATA.
  - DATA: shift the voted bit in LSB first. After DATA_BITS bits go to PARITY if PARITY≠0, else STOP.
  - PARITY: compare the voted bit with the computed parity. Even: XOR of data and parity bits = 0. Odd: XOR = 1.
  - STOP: the first stop bit (when STOP_BITS=2) runs the full bit. The last stop bit ends at its M+1 vote (mid-bit resync), where the frame is committed and the FSM goes to IDLE.
- Commit, when `valid`=0 or (`valid`&`ready`) in that cycle: load `data`, `parity_err`, `frame_err` and `brk`, and set `valid`.
- Commit when `valid`=1 and `ready`=0: discard the new frame, keep the old word and flags, and set `overrun`=1.
- Accept (`valid&ready` with no commit): clear `valid` and `overrun`. On a same-cycle accept and commit, `valid` stays 1 with the new word, and `overrun` clears.
- Error frames are delivered, not dropped; the flags travel with the word.
- `enabled`=0: the FSM goes to IDLE and `sc` to 0 on the next edge. A partial frame is dropped silently. The output register and handshake keep working.

## Timing
- Reset (rst=0 at an edge):
  - Outputs: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `brk`=0, `overrun`=0, `busy`=0.
  - Internal: FSM IDLE, counters 0.
  - Reset mid-frame abandons the frame with no flags.
- `rx` to `rx_s` latency is 2 `clk`. Start detection is quantised to 1 tick.
- `valid` rises on the `clk` edge after the commit tick. Frame-start to `valid` is about (1+DATA_BITS+P+STOP_BITS-1)·OVERSAMPLE+M+1 ticks, plus 2–3 `clk`.
- `busy` rises the edge after start detection and falls the edge after commit or false start.
- `valid` holds `data` stable until accepted. There is no combinational path from `ready` to `valid`.

## Test plan
- 8N1 defaults, send 0x73 (bits 1,1,0,0,1,1,1,0), `ready`=1 → single-cycle `valid` with `data`=0x73, all flags 0.
- PARITY=1, send 0xA5 with parity bit 0 → `data`=0xA5, `parity_err`=0. Same frame with parity bit 1 → `parity_err`=1.
- 8N1, send 0x3C with stop bit low → `frame_err`=1. Hold `rx` low for 12 bits → `data`=0, `frame_err`=1, `brk`=1.
- `ready`=0, send 0x11 then 0x22 → `data` stays 0x11, `overrun`=1. Pulse `ready` → `valid` falls and `overrun` clears.
- 4-tick low glitch on idle `rx` → false start, `busy` pulses, `valid` stays 0. Single-sample flip at `sc`=M inside a bit → majority keeps the correct value.
- Assert `rst`=0 (or `enabled`=0) during data bit 3, then send 0x5A → the first frame is lost with no flags, and `data`=0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: internal oversampling tick, 2-flop input synchroniser,
// 3-sample majority vote per bit, ready/valid holding register with error status.
module uart_rx_cfg #(
  parameter int CLK_DIV    = 23,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enabled,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 brk,
  output logic                 overrun,
  output logic                 busy
);

  localparam int M     = OVERSAMPLE / 2;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0]  SC_V0    = SC_W'(M - 1);
  localparam logic [SC_W-1:0]  SC_V1    = SC_W'(M);
  localparam logic [SC_W-1:0]  SC_V2    = SC_W'(M + 1);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("CLK_DIV must be at least 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("OVERSAMPLE must be even and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("DATA_BITS must be within 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic                 rx_meta_reg;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt_reg;
  logic                 tick;
  state_t               state_reg;
  logic [SC_W-1:0]      sc_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic                 samp0_reg;
  logic                 samp1_reg;
  logic                 vote_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_acc_reg;
  logic                 zero_acc_reg;
  logic                 fe_acc_reg;

  logic vote_now;
  logic last_stop;
  logic commit;
  logic commit_pe;
  logic commit_fe;
  logic commit_brk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  assign tick = (div_cnt_reg == DIV_LAST);

  // Third vote is taken live so the last stop bit can commit on its M+1 sample.
  assign vote_now  = (samp0_reg & samp1_reg) | (samp0_reg & rx_s) | (samp1_reg & rx_s);
  assign last_stop = (STOP_BITS == 1) || stop_cnt_reg;
  assign commit    = tick && enabled && (state_reg == ST_STOP) && last_stop && (sc_reg == SC_V2);

  always_comb begin
    commit_pe  = 1'b0;
    commit_fe  = fe_acc_reg | ~vote_now;
    commit_brk = zero_acc_reg & ~vote_now;
    if (PARITY == 1) begin
      commit_pe = par_acc_reg;
    end else if (PARITY == 2) begin
      commit_pe = ~par_acc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !enabled) begin
      state_reg    <= ST_IDLE;
      sc_reg       <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      samp0_reg    <= 1'b1;
      samp1_reg    <= 1'b1;
      vote_reg     <= 1'b1;
      shift_reg    <= '0;
      par_acc_reg  <= 1'b0;
      zero_acc_reg <= 1'b1;
      fe_acc_reg   <= 1'b0;
      busy         <= 1'b0;
    end else if (tick) begin
      if (state_reg == ST_IDLE) begin
        // The detecting tick is sample 0 of the start bit.
        if (!rx_s) begin
          state_reg <= ST_START;
          sc_reg    <= SC_ONE;
          busy      <= 1'b1;
        end
      end else begin
        if (sc_reg == SC_V0) samp0_reg <= rx_s;
        if (sc_reg == SC_V1) samp1_reg <= rx_s;
        if (sc_reg == SC_V2) vote_reg  <= vote_now;
        if (sc_reg == SC_LAST) begin
          sc_reg <= '0;
        end else begin
          sc_reg <= sc_reg + SC_ONE;
        end

        case (state_reg)
          ST_START: begin
            if (sc_reg == SC_LAST) begin
              if (vote_reg) begin
                state_reg <= ST_IDLE;
                busy      <= 1'b0;
              end else begin
                state_reg    <= ST_DATA;
                bit_cnt_reg  <= '0;
                par_acc_reg  <= 1'b0;
                zero_acc_reg <= 1'b1;
                fe_acc_reg   <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            if (sc_reg == SC_LAST) begin
              shift_reg    <= {vote_reg, shift_reg[DATA_BITS-1:1]};
              par_acc_reg  <= par_acc_reg ^ vote_reg;
              zero_acc_reg <= zero_acc_reg & ~vote_reg;
              if (bit_cnt_reg == BIT_LAST) begin
                state_reg    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                stop_cnt_reg <= 1'b0;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
              end
            end
          end
          ST_PARITY: begin
            if (sc_reg == SC_LAST) begin
              par_acc_reg  <= par_acc_reg ^ vote_reg;
              zero_acc_reg <= zero_acc_reg & ~vote_reg;
              state_reg    <= ST_STOP;
              stop_cnt_reg <= 1'b0;
            end
          end
          ST_STOP: begin
            if (!last_stop) begin
              if (sc_reg == SC_LAST) begin
                fe_acc_reg   <= fe_acc_reg | ~vote_reg;
                zero_acc_reg <= zero_acc_reg & ~vote_reg;
                stop_cnt_reg <= 1'b1;
              end
            end else if (sc_reg == SC_V2) begin
              // Leave mid-bit so the next start edge is caught without slip.
              state_reg <= ST_IDLE;
              sc_reg    <= '0;
              busy      <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            sc_reg    <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      if (!valid || ready) begin
        data       <= shift_reg;
        parity_err <= commit_pe;
        frame_err  <= commit_fe;
        brk        <= commit_brk;
        valid      <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        // Holding register still owned by the consumer: drop the new frame.
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
